// File: rtl/seven_seg_scan_controller.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_controller
//
// Time-multiplexed driver for a common-anode seven-segment display. Each
// digit owns a slot of REFRESH_DIV clock cycles. The first GUARD_CYCLES
// cycles of every slot are blanked so the previous digit's segment pattern
// cannot ghost onto the newly selected anode. The displayed values come from
// a snapshot taken once per frame, so a frame never mixes old and new data.
//
// Parameters
//   NUM_DIGITS   : multiplexed digit count, 2..8
//   REFRESH_DIV  : clock cycles per digit slot, >= 2
//   GUARD_CYCLES : blank cycles at the start of each slot, < REFRESH_DIV
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset      : synchronous active-high reset
//   digit_data : hex nibble per digit, nibble i = bits [4i+3:4i], digit 0 rightmost
//   digit_en   : per-digit enable, 0 blanks the digit
//   dp_in      : per-digit decimal point request
//   an         : active-low anode select, bit i drives digit i
//   seg        : active-low segments {g,f,e,d,c,b,a}
//   dp         : active-low decimal point
//   digit_idx  : index of the slot currently being scanned
//   frame_tick : one-cycle pulse in the cycle the snapshot loads
// ---------------------------------------------------------------------------
module seven_seg_scan_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [4*NUM_DIGITS-1:0]       digit_data,
    input  logic [NUM_DIGITS-1:0]         digit_en,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [6:0]                    seg,
    output logic                          dp,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_tick
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_GUARD,
        ST_DRIVE
    } state_e;

    // With no guard interval the block never enters GUARD, including out of reset.
    localparam state_e ST_RESET = (GUARD_CYCLES == 0) ? ST_DRIVE : ST_GUARD;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    state_e                  state_q, state_d;
    logic [4*NUM_DIGITS-1:0] snap_data_q, snap_data_d;
    logic [NUM_DIGITS-1:0]   snap_en_q, snap_en_d;
    logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    frame_tick_q, frame_tick_d;

    logic                    frame_load;
    logic                    guard_d;
    logic [3:0]              nibble_d;

    // -----------------------------------------------------------------------
    // Hex to active-low gfedcba decode
    // -----------------------------------------------------------------------
    function automatic logic [6:0] decode_hex(input logic [3:0] nib);
        logic [6:0] s;
        s = SEG_OFF;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

    // -----------------------------------------------------------------------
    // Slot counter, digit index and frame snapshot (next state)
    // -----------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path
    // through the block can leave a value unassigned and infer a latch.
    always_comb begin
        cnt_d       = cnt_q + CW'(1);
        idx_d       = idx_q;
        snap_data_d = snap_data_q;
        snap_en_d   = snap_en_q;
        snap_dp_d   = snap_dp_q;
        frame_load  = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);

        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end

        // The snapshot is taken only at the very end of a frame so a frame
        // never shows a mix of old and new digits.
        if (frame_load) begin
            snap_data_d = digit_data;
            snap_en_d   = digit_en;
            snap_dp_d   = dp_in;
        end
    end

    // Guard window test on the upcoming counter value. A zero-length guard is
    // handled structurally to avoid a comparison that is constant-false.
    if (GUARD_CYCLES == 0) begin : g_no_guard
        assign guard_d = 1'b0;
    end else begin : g_guard
        localparam logic [CW-1:0] GUARD_LIM = CW'(GUARD_CYCLES);
        assign guard_d = (cnt_d < GUARD_LIM);
    end

    // -----------------------------------------------------------------------
    // FSM next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_GUARD: if (!guard_d) state_d = ST_DRIVE;
            ST_DRIVE: if (guard_d)  state_d = ST_GUARD;
            default:  state_d = ST_RESET;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode. Computed from next-state values and then registered, so
    // the registered outputs line up with cnt/digit_idx of the same cycle and
    // no input reaches an output without passing through a flop.
    // -----------------------------------------------------------------------
    assign nibble_d = snap_data_d[{idx_d, 2'b00} +: 4];

    always_comb begin
        an_d         = '1;
        seg_d        = SEG_OFF;
        dp_d         = 1'b1;
        frame_tick_d = (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);

        if (state_d == ST_DRIVE && snap_en_d[idx_d]) begin
            an_d[idx_d] = 1'b0;
            seg_d       = decode_hex(nibble_d);
            dp_d        = ~snap_dp_d[idx_d];
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            state_q      <= ST_RESET;
            // NOTE: the snapshot is reset on purpose: cleared enables keep
            // the first frame after reset blank instead of showing stale data.
            snap_data_q  <= '0;
            snap_en_q    <= '0;
            snap_dp_q    <= '0;
            an_q         <= '1;
            seg_q        <= SEG_OFF;
            dp_q         <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            state_q      <= state_d;
            snap_data_q  <= snap_data_d;
            snap_en_q    <= snap_en_d;
            snap_dp_q    <= snap_dp_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign digit_idx  = idx_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_scan_controller
//
// Two instances share stimulus: u_dut with a one-cycle guard and u_dut0 with
// no guard, both with NUM_DIGITS=4 and REFRESH_DIV=4 (16-cycle frames).
// Outputs are sampled on the falling clock edge; inputs change there too.
// ---------------------------------------------------------------------------
module tb_seven_seg_scan_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digit_data;
    logic [3:0]  digit_en;
    logic [3:0]  dp_in;

    logic [3:0]  an,  an0;
    logic [6:0]  seg, seg0;
    logic        dp,  dp0;
    logic [1:0]  digit_idx, digit_idx0;
    logic        frame_tick, frame_tick0;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected active-low gfedcba patterns for hex 0..F.
    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    always #5 clk = ~clk;

    seven_seg_scan_controller #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4),
        .GUARD_CYCLES(1)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .digit_data(digit_data),
        .digit_en  (digit_en),
        .dp_in     (dp_in),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .digit_idx (digit_idx),
        .frame_tick(frame_tick)
    );

    seven_seg_scan_controller #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4),
        .GUARD_CYCLES(0)
    ) u_dut0 (
        .clk       (clk),
        .reset     (reset),
        .digit_data(digit_data),
        .digit_en  (digit_en),
        .dp_in     (dp_in),
        .an        (an0),
        .seg       (seg0),
        .dp        (dp0),
        .digit_idx (digit_idx0),
        .frame_tick(frame_tick0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "/an"},    32'(an),          32'hF);
        check({tag, "/seg"},   32'(seg),         32'h7F);
        check({tag, "/dp"},    32'(dp),          32'h1);
        check({tag, "/idx"},   32'(digit_idx),   32'h0);
        check({tag, "/tick"},  32'(frame_tick),  32'h0);
        check({tag, "/an0"},   32'(an0),         32'hF);
        check({tag, "/seg0"},  32'(seg0),        32'h7F);
        check({tag, "/dp0"},   32'(dp0),         32'h1);
        check({tag, "/idx0"},  32'(digit_idx0),  32'h0);
        check({tag, "/tick0"}, 32'(frame_tick0), 32'h0);
    endtask

    // Expected outputs for cycle k of a frame whose snapshot is data/en/dpin.
    task automatic check_cycle(input string tag, input bit has_guard, input int k,
                               input logic [15:0] data, input logic [3:0] en,
                               input logic [3:0] dpin,
                               input logic [3:0] an_o, input logic [6:0] seg_o,
                               input logic dp_o, input logic [1:0] idx_o,
                               input logic tick_o);
        int         s;
        int         c;
        bit         drive;
        logic [3:0] nib;
        logic [3:0] an_e;
        logic [6:0] seg_e;
        logic       dp_e;
        s     = k / 4;
        c     = k % 4;
        drive = !(has_guard && c == 0) && en[s];
        nib   = data[4*s +: 4];
        an_e  = drive ? ~(4'b0001 << s) : 4'hF;
        seg_e = drive ? SEG_TAB[nib] : 7'h7F;
        dp_e  = drive ? ~dpin[s] : 1'b1;
        check($sformatf("%s/c%0d/an", tag, k),   32'(an_o),   32'(an_e));
        check($sformatf("%s/c%0d/seg", tag, k),  32'(seg_o),  32'(seg_e));
        check($sformatf("%s/c%0d/dp", tag, k),   32'(dp_o),   32'(dp_e));
        check($sformatf("%s/c%0d/idx", tag, k),  32'(idx_o),  32'(s));
        check($sformatf("%s/c%0d/tick", tag, k), 32'(tick_o), 32'(k == 15));
    endtask

    // Checks ncyc cycles of a frame on both instances, starting at the falling
    // edge of cycle 0; optionally changes the inputs after checking cycle chg_k.
    task automatic run_frame(input string name, input int ncyc,
                             input logic [15:0] data, input logic [3:0] en,
                             input logic [3:0] dpin, input int chg_k,
                             input logic [15:0] n_data, input logic [3:0] n_en,
                             input logic [3:0] n_dp);
        for (int k = 0; k < ncyc; k++) begin
            check_cycle({name, "/g1"}, 1'b1, k, data, en, dpin,
                        an, seg, dp, digit_idx, frame_tick);
            check_cycle({name, "/g0"}, 1'b0, k, data, en, dpin,
                        an0, seg0, dp0, digit_idx0, frame_tick0);
            if (k == chg_k) begin
                digit_data = n_data;
                digit_en   = n_en;
                dp_in      = n_dp;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        digit_data = 16'h3210;
        digit_en   = 4'hF;
        dp_in      = 4'h0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        reset = 1'b0;

        // Frame 0: snapshot cleared by reset, blank; loads 3210 at cycle 15.
        run_frame("f0_blank", 16, 16'h0000, 4'h0, 4'h0, -1, 16'h0, 4'h0, 4'h0);
        // Frame 1: shows 3210; data changes to FFFF during slot 1.
        run_frame("f1_3210", 16, 16'h3210, 4'hF, 4'h0, 5, 16'hFFFF, 4'hF, 4'h0);
        // Frame 2: F everywhere; enables/dp change mid-frame.
        run_frame("f2_ffff", 16, 16'hFFFF, 4'hF, 4'h0, 6, 16'hFFFF, 4'b1011, 4'b0001);
        // Frame 3: digit 2 blanked, decimal point on digit 0.
        run_frame("f3_blank_dp", 16, 16'hFFFF, 4'b1011, 4'b0001, -1, 16'h0, 4'h0, 4'h0);
        // Frame 4: run into slot 2, cnt 2, then reset.
        run_frame("f4_pre_rst", 10, 16'hFFFF, 4'b1011, 4'b0001, -1, 16'h0, 4'h0, 4'h0);
        check("f4_mid/idx",  32'(digit_idx),  32'h2);
        check("f4_mid/idx0", 32'(digit_idx0), 32'h2);
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("mid_reset");
        reset = 1'b0;
        // Frame 5: blank again after reset; reloads the held inputs at cycle 15.
        run_frame("f5_post_rst", 16, 16'h0000, 4'h0, 4'h0, -1, 16'h0, 4'h0, 4'h0);
        // Frame 6: reloaded snapshot displayed.
        run_frame("f6_reload", 16, 16'hFFFF, 4'b1011, 4'b0001, -1, 16'h0, 4'h0, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_controller.md
SEVEN_SEG_SCAN_CONTROLLER -- requirements
Module: seven_seg_scan_controller

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 2..8.
REQ-002 SHALL have parameter REFRESH_DIV, default 100000: clock cycles per digit slot, minimum 2.
REQ-003 SHALL have parameter GUARD_CYCLES, default 16: anti-ghosting blank cycles at slot start, 0 <= GUARD_CYCLES < REFRESH_DIV.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port digit_data, input, 4*NUM_DIGITS bits: hex nibble per digit; nibble i is bits [4i+3:4i], and digit 0 is rightmost.
REQ-007 SHALL have port digit_en, input, NUM_DIGITS bits: per-digit enable; 0 blanks that digit.
REQ-008 SHALL have port dp_in, input, NUM_DIGITS bits: per-digit decimal point request.
REQ-009 SHALL have port an, output, NUM_DIGITS bits: active-low anode select; bit i drives digit i.
REQ-010 SHALL have port seg, output, 7 bits: active-low segments {g,f,e,d,c,b,a}.
REQ-011 SHALL have port dp, output, 1 bit: active-low decimal point.
REQ-012 SHALL have port digit_idx, output, $clog2(NUM_DIGITS) bits: index of the current slot.
REQ-013 SHALL have port frame_tick, output, 1 bit: one-cycle pulse in the cycle the snapshot loads.

Function
REQ-014 SHALL hold a slot counter cnt running 0..REFRESH_DIV-1; at REFRESH_DIV-1 it wraps to 0 and digit_idx advances.
REQ-015 SHALL advance digit_idx 0,1,...,NUM_DIGITS-1 and wrap to 0; no other values are reachable.
REQ-016 SHALL implement two states: GUARD while cnt < GUARD_CYCLES, DRIVE otherwise; GUARD_CYCLES=0 means the block is always in DRIVE.
REQ-017 SHALL, in GUARD, drive an all-ones, seg 7'b1111111 and dp 1.
REQ-018 SHALL, in DRIVE, drive an with only bit digit_idx low, provided snapshot enable bit digit_idx is 1; otherwise an is all-ones and seg/dp are off.
REQ-019 SHALL decode the nibble (active-low gfedcba) as: 0->1000000, 1->1111001, 2->0100100, 3->0110000, 4->0011001, 5->0010010, 6->0000010, 7->1111000, 8->0000000, 9->0010000, A->0001000, b->0000011, C->1000110, d->0100001, E->0000110, F->0001110.
REQ-020 SHALL drive dp = ~snapshot dp bit of the current digit in DRIVE.
REQ-021 SHALL register an, seg and dp; they reflect the cnt/digit_idx state of the same cycle, with no combinational path from any input to any output.
REQ-022 SHALL load snapshot registers (digit_data, digit_en, dp_in) only in the cycle where cnt=REFRESH_DIV-1 and digit_idx=NUM_DIGITS-1, asserting frame_tick in that same cycle; input changes mid-frame SHALL NOT appear until the next frame.
REQ-023 SHALL give reset priority over the snapshot load when both occur in the same cycle.

Reset
REQ-024 SHALL, while reset is high at a clock edge, set cnt=0, digit_idx=0, state=GUARD (or DRIVE if GUARD_CYCLES=0), all snapshot registers=0, an=all-ones, seg=7'b1111111, dp=1 and frame_tick=0.
REQ-025 SHALL, with snapshot enables cleared, display blank for the first frame after reset; the first frame_tick occurs NUM_DIGITS*REFRESH_DIV cycles after reset deasserts.
REQ-026 SHALL, on reset asserted mid-slot or mid-frame, return to the REQ-024 values at the next edge, discarding partial slot progress.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=1)
REQ-027 SHALL cover reset then digit_data=16'h3210, digit_en=4'hF held: cycles 0-15 show an=1111; frame_tick pulses at cycle 15; the slot at cycles 16-19 shows an=1111 at cnt=0, then an=1110, seg=1000000 for 3 cycles; the next slot shows an=1101, seg=1111001.
REQ-028 SHALL cover the scan order: digit_idx sequence is 0,1,2,3,0 with exactly 4 cycles per value, and frame_tick occurs once every 16 cycles.
REQ-029 SHALL cover a mid-frame change: digit_data changes from 16'h3210 to 16'hFFFF during slot 1; slots 2 and 3 still show 2 and 3, and F (0001110) appears only after the next frame_tick.
REQ-030 SHALL cover blanking and decimal point: digit_en=4'b1011, dp_in=4'b0001; slot 2 has an=1111, and slot 0 has dp=0 during DRIVE and dp=1 during GUARD.
REQ-031 SHALL cover reset pulsed at cnt=2 of slot 2: at the next edge digit_idx=0, cnt=0, an=1111, and the next frame is blank.
REQ-032 SHALL cover the GUARD_CYCLES=0 build: no all-ones an cycle between enabled digits, and each digit is driven for all 4 cycles.
